// File: rtl/fifo_arb_pkg.sv
// Shared arbiter state encoding and burst-counter sizing for fifo_push_arbiter.
// Burst counter holds 0..maxBurst inclusive, hence one bit beyond $clog2.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BURST  = 2'd2
  } arb_state_e;

  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first asserted request at or after start_idx wins.
// Purely combinational, no state; vld=0 when no request is asserted.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start_idx,
  output logic [N-1:0]         gnt,
  output logic                 vld
);

  always_comb begin : pick
    int idx;
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start_idx) + k;
      if (idx >= N) idx = idx - N;
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port; 0-cycle request-to-push, no push while fifoFull.
// FIFO_ARB_BURST_EN lets the last owner keep priority for up to maxBurst consecutive grants.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int nrOfRequesters = 4,
  parameter int bitWidth       = 32,
  parameter int maxBurst       = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [nrOfRequesters-1:0]          request,
  input  logic [nrOfRequesters*bitWidth-1:0] requestData,
  input  logic                               fifoFull,
  output logic [nrOfRequesters-1:0]          grant,
  output logic                               push,
  output logic [bitWidth-1:0]                pushData,
  output logic [$clog2(nrOfRequesters)-1:0]  ownerId,
  output logic                               stalled
);

  localparam int IW = $clog2(nrOfRequesters);

  if (nrOfRequesters < 2 || nrOfRequesters > 16 || maxBurst < 1 || maxBurst > 16) begin : g_bad_cfg
    $error("fifo_push_arbiter: parameter out of range");
  end

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       owner_inc;
  logic [IW-1:0]       start_idx;
  logic [IW-1:0]       gnt_idx;
  logic [nrOfRequesters-1:0] pick_gnt;
  logic                pick_vld;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = burst_cnt_width(maxBurst);
  localparam logic [CW-1:0] CNT_MAX = CW'(maxBurst);

  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          burst_hold;

  assign burst_hold = (state_q == BURST) && request[owner_q] && (burst_cnt_q < CNT_MAX);
  assign start_idx  = burst_hold ? owner_q : owner_inc;
`else
  assign start_idx  = owner_inc;
`endif

  assign owner_inc = (owner_q == IW'(nrOfRequesters - 1)) ? '0 : owner_q + 1'b1;

  rr_priority_pick #(.N(nrOfRequesters)) u_pick (
    .req       (request),
    .start_idx (start_idx),
    .gnt       (pick_gnt),
    .vld       (pick_vld)
  );

  // Outputs are gated by reset so they read zero the instant reset asserts.
  assign grant   = (reset && !fifoFull && pick_vld) ? pick_gnt : '0;
  assign push    = |grant;
  assign stalled = (|request) && fifoFull;
  assign ownerId = owner_q;

  always_comb begin
    pushData = '0;
    gnt_idx  = '0;
    for (int i = 0; i < nrOfRequesters; i++) begin
      if (grant[i]) begin
        pushData = pushData | requestData[i*bitWidth +: bitWidth];
        gnt_idx  = IW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (push) begin
      owner_d = gnt_idx;
`ifdef FIFO_ARB_BURST_EN
      state_d = BURST;
`else
      state_d = ACTIVE;
`endif
    end else if (!(|request)) begin
      state_d = IDLE;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (push) burst_cnt_d = burst_hold ? burst_cnt_q + 1'b1 : CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= IW'(nrOfRequesters - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized self-checking bench for fifo_push_arbiter against a queue/arithmetic reference model.
// Build with +define+FIFO_ARB_BURST_EN to exercise burst ownership.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic             clock;
  logic             reset;
  logic [N-1:0]     request;
  logic [N*W-1:0]   requestData;
  logic             fifoFull;
  logic [N-1:0]     grant;
  logic             push;
  logic [W-1:0]     pushData;
  logic [1:0]       ownerId;
  logic             stalled;

  int errors = 0;
  int checks = 0;

  int m_owner;
  int m_cnt;
  bit m_burst;

  logic [W-1:0] dat [N];
  logic [W-1:0] send_q [N][$];
  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] fifo_q [$];

  fifo_push_arbiter #(.nrOfRequesters(N), .bitWidth(W), .maxBurst(MB)) dut (
    .clock       (clock),
    .reset       (reset),
    .request     (request),
    .requestData (requestData),
    .fifoFull    (fifoFull),
    .grant       (grant),
    .push        (push),
    .pushData    (pushData),
    .ownerId     (ownerId),
    .stalled     (stalled)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model_pick(input logic [N-1:0] req, input logic full);
    if (full || req == '0) return -1;
`ifdef FIFO_ARB_BURST_EN
    if (m_burst && req[m_owner] && m_cnt < MB) return m_owner;
`endif
    for (int k = 1; k <= N; k++)
      if (req[(m_owner + k) % N]) return (m_owner + k) % N;
    return -1;
  endfunction

  task automatic model_commit(input logic [N-1:0] req, input logic full);
    int g;
    bit hold;
    g    = model_pick(req, full);
    hold = m_burst && req[m_owner] && (m_cnt < MB);
    if (g >= 0) begin
      m_cnt   = hold ? m_cnt + 1 : 1;
      m_owner = g;
      m_burst = 1'b1;
    end else if (req == '0) begin
      m_burst = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_owner = N - 1;
    m_cnt   = 0;
    m_burst = 1'b0;
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic load_data();
    for (int p = 0; p < N; p++) requestData[p*W +: W] = dat[p];
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    request  = '0;
    fifoFull = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    request  = 4'b1111;
    fifoFull = 1'b0;
    for (int p = 0; p < N; p++) dat[p] = $urandom;
    load_data();
    for (int c = 0; c < 2; c++) begin
      #3;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", push); end
      checks++; if (pushData !== '0) begin errors++; $display("FAIL reset_pushData: got %h want 0", pushData); end
      checks++; if (ownerId !== 2'd3) begin errors++; $display("FAIL reset_ownerId: got %0d want 3", ownerId); end
      @(posedge clock); #1;
    end
    reset   = 1'b1;
    request = '0;
    model_reset();
  endtask

  task automatic test_single();
    dat[0] = 32'h0000_00A5;
    load_data();
    request = 4'b0001;
    #3;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
    checks++; if (push !== 1'b1) begin errors++; $display("FAIL single_push: got %b want 1", push); end
    checks++; if (pushData !== 32'h0000_00A5) begin errors++; $display("FAIL single_pushData: got %h want a5", pushData); end
    checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL single_stalled: got %b want 0", stalled); end
    model_commit(request, fifoFull);
    @(posedge clock); #1;
    request = '0;
    #3;
    checks++; if (ownerId !== 2'd0) begin errors++; $display("FAIL single_ownerId: got %0d want 0", ownerId); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL single_idle_push: got %b want 0", push); end
    model_commit(request, fifoFull);
    @(posedge clock); #1;
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int p = 0; p < N; p++) dat[p] = $urandom;
    load_data();
    request = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #3;
      g = model_pick(request, fifoFull);
`ifndef FIFO_ARB_BURST_EN
      checks++; if (grant !== onehot(c % N)) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", c, grant, onehot(c % N)); end
`endif
      checks++; if (grant !== onehot(g)) begin errors++; $display("FAIL rr_model[%0d]: got %b want %b", c, grant, onehot(g)); end
      checks++; if (g >= 0 && pushData !== dat[g]) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", c, pushData, dat[g]); end
      model_commit(request, fifoFull);
      @(posedge clock); #1;
    end
  endtask

  task automatic test_full_stall();
    int g;
    logic [1:0] own_before;
    request    = 4'b1111;
    fifoFull   = 1'b1;
    own_before = ownerId;
    for (int c = 0; c < 3; c++) begin
      #3;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL full_grant[%0d]: got %b want 0000", c, grant); end
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL full_push[%0d]: got %b want 0", c, push); end
      checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL full_stalled[%0d]: got %b want 1", c, stalled); end
      checks++; if (pushData !== '0) begin errors++; $display("FAIL full_pushData[%0d]: got %h want 0", c, pushData); end
      checks++; if (ownerId !== own_before) begin errors++; $display("FAIL full_owner[%0d]: got %0d want %0d", c, ownerId, own_before); end
      model_commit(request, fifoFull);
      @(posedge clock); #1;
    end
    fifoFull = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #3;
      g = model_pick(request, fifoFull);
      checks++; if (grant !== onehot(g)) begin errors++; $display("FAIL resume[%0d]: got %b want %b", c, grant, onehot(g)); end
      checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL resume_stalled[%0d]: got %b want 0", c, stalled); end
      model_commit(request, fifoFull);
      @(posedge clock); #1;
    end
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst();
    int exp_seq [8];
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
    do_reset();
    request = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      #3;
      checks++; if (grant !== onehot(exp_seq[c])) begin errors++; $display("FAIL burst[%0d]: got %b want %b", c, grant, onehot(exp_seq[c])); end
      model_commit(request, fifoFull);
      @(posedge clock); #1;
    end
  endtask
`endif

  task automatic test_reset_mid_burst();
    do_reset();
    request = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      #3;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midburst_pre[%0d]: got %b want 0100", c, grant); end
      model_commit(request, fifoFull);
      @(posedge clock); #1;
    end
    request = 4'b1110;
    #1;
    reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midburst_grant: got %b want 0000", grant); end
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL midburst_push: got %b want 0", push); end
    checks++; if (pushData !== '0) begin errors++; $display("FAIL midburst_pushData: got %h want 0", pushData); end
    checks++; if (ownerId !== 2'd3) begin errors++; $display("FAIL midburst_owner: got %0d want 3", ownerId); end
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    #3;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL midburst_first: got %b want 0010", grant); end
    model_commit(request, fifoFull);
    @(posedge clock); #1;
    request = '0;
    model_commit(request, fifoFull);
    @(posedge clock); #1;
  endtask

  task automatic test_random_fifo();
    logic [N-1:0] hreq;
    logic [W-1:0] w;
    int g, gp, p, delivered, cycle;
    do_reset();
    hreq = '0;
    for (int i = 0; i < 100; i++) begin
      p = $urandom_range(0, N - 1);
      w = {4'(p), 12'(i), 16'($urandom)};
      send_q[p].push_back(w);
      exp_q[p].push_back(w);
    end
    delivered = 0;
    cycle     = 0;
    while (delivered < 100 && cycle < 5000) begin
      for (int q = 0; q < N; q++) begin
        if (!hreq[q] && send_q[q].size() > 0 && $urandom_range(0, 3) != 0) hreq[q] = 1'b1;
        requestData[q*W +: W] = hreq[q] ? send_q[q][0] : W'($urandom);
      end
      request  = hreq;
      fifoFull = (fifo_q.size() == 16);
      #3;
      g = model_pick(request, fifoFull);
      checks++; if (grant !== onehot(g)) begin errors++; $display("FAIL rand_grant cyc %0d: got %b want %b", cycle, grant, onehot(g)); end
      checks++; if (push && fifoFull) begin errors++; $display("FAIL rand_push_full cyc %0d: got push=1 want 0", cycle); end
      checks++; if (stalled !== ((|request) && fifoFull)) begin errors++; $display("FAIL rand_stalled cyc %0d: got %b want %b", cycle, stalled, (|request) && fifoFull); end
      checks++; if (ownerId !== 2'(m_owner)) begin errors++; $display("FAIL rand_owner cyc %0d: got %0d want %0d", cycle, ownerId, m_owner); end
      if (push) begin
        gp = -1;
        for (int q = 0; q < N; q++) if (grant[q]) gp = q;
        if (gp >= 0 && hreq[gp]) begin
          checks++; if (pushData !== send_q[gp][0]) begin errors++; $display("FAIL rand_data cyc %0d: got %h want %h", cycle, pushData, send_q[gp][0]); end
          fifo_q.push_back(pushData);
          void'(send_q[gp].pop_front());
          hreq[gp] = 1'b0;
        end
      end
      model_commit(request, fifoFull);
      if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        w = fifo_q.pop_front();
        p = int'(w[31:28]);
        checks++;
        if (p >= N || exp_q[p].size() == 0 || w !== exp_q[p][0]) begin
          errors++;
          $display("FAIL rand_order: got %h want next word of producer %0d", w, p);
        end else begin
          void'(exp_q[p].pop_front());
          delivered++;
        end
      end
      @(posedge clock); #1;
      cycle++;
    end
    request = '0;
    checks++; if (delivered !== 100) begin errors++; $display("FAIL rand_delivered: got %0d want 100", delivered); end
  endtask

  initial begin
    reset       = 1'b0;
    request     = '0;
    requestData = '0;
    fifoFull    = 1'b0;
    model_reset();
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`endif
    test_reset_mid_burst();
    test_random_fifo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
